featuremap_accum_pipe: RTL and testbench

FEATUREMAP_ACCUM_PIPE -- requirements
Module: featuremap_accum_pipe

---
 rtl/featuremap_accum_pipe_pkg.sv | 29 ++
 rtl/featuremap_accum_pipe_adder_tree.sv | 44 ++++
 rtl/featuremap_accum_pipe.sv | 153 +++++++++++++++
 tb/tb_featuremap_accum_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/featuremap_accum_pipe_pkg.sv
// Shared constants and helpers for the featuremap accumulation pipeline:
// width derivation, leaky slope shift and saturation bounds.
package featuremap_pkg;

   localparam int LEAKY_SHIFT = 3;

   // Ceiling log2; returns 0 for n <= 1 so a single lane gives a zero-level tree.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic int acc_width(input int data_w, input int num_ch);
      return data_w + clog2(num_ch) + 1;
   endfunction

   function automatic longint sat_max(input int data_w);
      return (longint'(1) <<< (data_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int data_w);
      return -(longint'(1) <<< (data_w - 1));
   endfunction

endpackage

// File: rtl/featuremap_accum_pipe_adder_tree.sv
// Registered binary reduction tree: one register level per tree level,
// all levels enabled together by the pipeline advance signal.
module adder_tree_pipe
   import featuremap_pkg::*;
#(
   parameter int NUM_CH = 32,
   parameter int ACC_W  = 38
) (
   input  logic                    Clk,
   input  logic                    advance,
   input  logic [NUM_CH*ACC_W-1:0] sum_in,
   output logic [ACC_W-1:0]        sum_out
);

   localparam int LEVELS = clog2(NUM_CH);
   localparam int LEAVES = 1 << LEVELS;

   // Level 0 is the combinational leaf row; leaves beyond NUM_CH read as zero.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int N = LEAVES >> l;
      logic signed [ACC_W-1:0] node [N];

      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < N; i++) begin : g_node
            if (i < NUM_CH) begin : g_lane
               assign node[i] = sum_in[i*ACC_W +: ACC_W];
            end else begin : g_pad
               assign node[i] = '0;
            end
         end
      end else begin : g_add
         always_ff @(posedge Clk) begin
            if (advance) begin
               for (int j = 0; j < N; j++) begin
                  node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
               end
            end
         end
      end
   end

   assign sum_out = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/featuremap_accum_pipe.sv
// Channel accumulation pipeline: adder tree, bias add, leaky activation and
// saturation, with a global-stall handshake and per-frame last marking.
module featuremap_accum_pipe
   import featuremap_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 32,
   parameter int IMG_SIZE   = 104,
   parameter int LEAKY_EN   = 1
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [DATA_WIDTH-1:0]        bias_in,
   input  logic                         bias_load,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic                         last_out
);

   localparam int LEVELS = clog2(NUM_CH);
   localparam int ACC_W  = acc_width(DATA_WIDTH, NUM_CH);
   localparam int PIX    = IMG_SIZE * IMG_SIZE;
   localparam int CNT_W  = clog2(PIX + 1);

   localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(sat_min(DATA_WIDTH));
   localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(PIX - 1);

   logic                         advance;
   logic                         accept;
   logic signed [DATA_WIDTH-1:0] bias_reg;
   logic [NUM_CH*ACC_W-1:0]      lanes_ext;
   logic signed [ACC_W-1:0]      tree_sum;
   logic                         tree_valid;
   logic signed [DATA_WIDTH-1:0] tree_bias;
   logic signed [ACC_W-1:0]      biased_sum;
   logic                         biased_valid;
   logic signed [ACC_W-1:0]      act_sum;
   logic signed [ACC_W-1:0]      sat_sum;
   logic [CNT_W-1:0]             pix_cnt;

   assign advance  = ready_out || !valid_out;
   assign ready_in = advance;
   assign accept   = valid_in && advance;

   always_comb begin
      lanes_ext = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         lanes_ext[k*ACC_W +: ACC_W] = ACC_W'($signed(data_in[k*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         bias_reg <= '0;
      end else if (bias_load) begin
         bias_reg <= bias_in;
      end
   end

   adder_tree_pipe #(
      .NUM_CH (NUM_CH),
      .ACC_W  (ACC_W)
   ) u_tree (
      .Clk     (Clk),
      .advance (advance),
      .sum_in  (lanes_ext),
      .sum_out (tree_sum)
   );

   // Valid and bias ride alongside the tree so each pixel keeps the bias seen at acceptance.
   if (LEVELS == 0) begin : g_no_delay
      assign tree_valid = accept;
      assign tree_bias  = bias_reg;
   end else begin : g_delay
      logic                         vld_pipe  [LEVELS];
      logic signed [DATA_WIDTH-1:0] bias_pipe [LEVELS];

      always_ff @(posedge Clk) begin
         if (Rst) begin
            for (int i = 0; i < LEVELS; i++) begin
               vld_pipe[i] <= 1'b0;
            end
         end else if (advance) begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < LEVELS; i++) begin
               vld_pipe[i] <= vld_pipe[i-1];
            end
         end
      end

      always_ff @(posedge Clk) begin
         if (advance) begin
            bias_pipe[0] <= bias_reg;
            for (int i = 1; i < LEVELS; i++) begin
               bias_pipe[i] <= bias_pipe[i-1];
            end
         end
      end

      assign tree_valid = vld_pipe[LEVELS-1];
      assign tree_bias  = bias_pipe[LEVELS-1];
   end

   always_ff @(posedge Clk) begin
      if (advance) begin
         biased_sum <= tree_sum + ACC_W'(tree_bias);
      end
   end

   // Arithmetic shift gives the floor-rounded 1/8 slope for negative sums.
   always_comb begin
      act_sum = biased_sum;
      if (LEAKY_EN != 0 && biased_sum < 0) begin
         act_sum = biased_sum >>> LEAKY_SHIFT;
      end
      sat_sum = act_sum;
      if (act_sum > SAT_HI) begin
         sat_sum = SAT_HI;
      end else if (act_sum < SAT_LO) begin
         sat_sum = SAT_LO;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         biased_valid <= 1'b0;
         valid_out    <= 1'b0;
         data_out     <= '0;
      end else if (advance) begin
         biased_valid <= tree_valid;
         valid_out    <= biased_valid;
         if (biased_valid) begin
            data_out <= sat_sum[DATA_WIDTH-1:0];
         end
      end
   end

   assign last_out = valid_out && (pix_cnt == LAST_IDX);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pix_cnt <= '0;
      end else if (valid_out && ready_out) begin
         pix_cnt <= last_out ? '0 : pix_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_featuremap_accum_pipe.sv
// Randomized bench for featuremap_accum_pipe: a leaky and a linear instance
// share stimulus and are scored against a queue-based arithmetic model.
module tb_featuremap_accum_pipe;

   localparam int DW  = 32;
   localparam int NCH = 32;
   localparam int IMG = 4;
   localparam int PIX = IMG * IMG;
   localparam int LAT = 7;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [DW-1:0] leaky;
      logic [DW-1:0] lin;
   } exp_t;

   logic            Clk = 1'b0;
   logic            Rst = 1'b1;
   logic [NCH*DW-1:0] data_in = '0;
   logic            valid_in = 1'b0;
   logic            bias_load = 1'b0;
   logic            ready_out = 1'b1;
   logic [DW-1:0]   bias_in = '0;

   logic            ready_in, valid_out, last_out;
   logic [DW-1:0]   data_out;
   logic            ready_lin, valid_lin, last_lin;
   logic [DW-1:0]   data_lin;

   int     num_checks = 0;
   int     num_passed = 0;
   exp_t   exp_q[$];
   longint model_bias = 0;
   int     out_idx = 0;
   int     last_seen = 0;
   logic   stall_prev = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic   stall_last = 1'b0;
   bit     rand_done = 1'b0;

   featuremap_accum_pipe #(
      .DATA_WIDTH (DW), .NUM_CH (NCH), .IMG_SIZE (IMG), .LEAKY_EN (1)
   ) dut (
      .Clk (Clk), .Rst (Rst), .data_in (data_in), .valid_in (valid_in),
      .ready_in (ready_in), .bias_in (bias_in), .bias_load (bias_load),
      .data_out (data_out), .valid_out (valid_out), .ready_out (ready_out),
      .last_out (last_out)
   );

   featuremap_accum_pipe #(
      .DATA_WIDTH (DW), .NUM_CH (NCH), .IMG_SIZE (IMG), .LEAKY_EN (0)
   ) dut_lin (
      .Clk (Clk), .Rst (Rst), .data_in (data_in), .valid_in (valid_in),
      .ready_in (ready_lin), .bias_in (bias_in), .bias_load (bias_load),
      .data_out (data_lin), .valid_out (valid_lin), .ready_out (ready_out),
      .last_out (last_lin)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed === expected) num_passed++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic longint clampSat(input longint v);
      if (v > SMAX) return SMAX;
      if (v < SMIN) return SMIN;
      return v;
   endfunction

   // Plain integer arithmetic: full sum, floor-divide by 8 when negative, clamp.
   function automatic exp_t refPixel(input logic [NCH*DW-1:0] d, input longint bias);
      longint s, lk;
      exp_t e;
      s = bias;
      for (int k = 0; k < NCH; k++) s += longint'($signed(d[k*DW +: DW]));
      lk = (s < 0) ? -((-s + 7) / 8) : s;
      e.leaky = DW'(clampSat(lk));
      e.lin   = DW'(clampSat(s));
      return e;
   endfunction

   function automatic logic [NCH*DW-1:0] randPixel();
      logic [NCH*DW-1:0] d;
      int mode;
      mode = $urandom_range(0, 3);
      d = '0;
      for (int k = 0; k < NCH; k++) begin
         case (mode)
            0: d[k*DW +: DW] = $urandom();
            1: d[k*DW +: DW] = DW'($urandom_range(0, 2000)) - 32'd1000;
            2: d[k*DW +: DW] = 32'h7FFF_FFFF - DW'($urandom_range(0, 3));
            default: d[k*DW +: DW] = 32'h8000_0000 + DW'($urandom_range(0, 3));
         endcase
      end
      return d;
   endfunction

   // Scoreboard: observe each edge's transfers at the preceding falling edge.
   always @(negedge Clk) begin
      exp_t e;
      if (Rst) begin
         exp_q.delete();
         model_bias = 0;
         out_idx = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checkOutput("stall_data_hold", data_out, stall_data);
            checkOutput("stall_valid_hold", valid_out, 1'b1);
            checkOutput("stall_last_hold", last_out, stall_last);
         end
         if (valid_out && !ready_out) checkOutput("stall_ready_in", ready_in, 1'b0);
         if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_valid_out", valid_out, 1'b0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("data_leaky", data_out, e.leaky);
               checkOutput("data_linear", data_lin, e.lin);
               checkOutput("valid_linear", valid_lin, 1'b1);
               checkOutput("last_out", last_out, out_idx == PIX - 1);
               checkOutput("last_linear", last_lin, out_idx == PIX - 1);
               if (last_out) last_seen++;
               out_idx = (out_idx + 1) % PIX;
            end
         end
         if (valid_in && ready_in) exp_q.push_back(refPixel(data_in, model_bias));
         if (bias_load) model_bias = longint'($signed(bias_in));
         stall_prev = valid_out && !ready_out;
         stall_data = data_out;
         stall_last = last_out;
      end
   end

   task automatic applyStimulus(input logic [NCH*DW-1:0] d, input logic ld, input logic [DW-1:0] b);
      logic taken;
      int waited;
      taken = 1'b0;
      waited = 0;
      data_in = d;
      valid_in = 1'b1;
      bias_load = ld;
      bias_in = b;
      while (!taken && waited < 200) begin
         @(negedge Clk);
         taken = ready_in;
         @(posedge Clk);
         #1;
         bias_load = 1'b0;
         waited++;
      end
      if (!taken) checkOutput("accept_timeout", ready_in, 1'b1);
      valid_in = 1'b0;
   endtask

   task automatic loadBias(input logic [DW-1:0] b);
      bias_in = b;
      bias_load = 1'b1;
      @(posedge Clk);
      #1;
      bias_load = 1'b0;
   endtask

   task automatic pulseReset();
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      ready_out = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge Clk);
         #1;
         n++;
      end
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [NCH*DW-1:0] px;
      int lat;

      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;
      checkOutput("reset_valid_out", valid_out, 1'b0);
      checkOutput("reset_last_out", last_out, 1'b0);
      checkOutput("reset_data_out", data_out, 32'h0);
      checkOutput("reset_ready_in", ready_in, 1'b1);

      // Single pixel of all-ones lanes: latency L-1 edges, one-cycle valid.
      applyStimulus({NCH{32'h0000_0001}}, 1'b0, '0);
      lat = 0;
      while (!valid_out && lat < 20) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      checkOutput("first_latency", lat, LAT - 1);
      checkOutput("first_data", data_out, 32'd32);
      @(posedge Clk);
      #1;
      checkOutput("single_valid_pulse", valid_out, 1'b0);

      loadBias(32'hFFFF_FFF8);
      applyStimulus({NCH{32'hFFFF_FFFF}}, 1'b0, '0);
      waitDrain();
      checkOutput("leaky_neg_data", data_out, 32'hFFFF_FFFB);
      checkOutput("linear_neg_data", data_lin, 32'hFFFF_FFD8);

      loadBias(32'h0);
      applyStimulus({NCH{32'h7FFF_FFFF}}, 1'b0, '0);
      applyStimulus({NCH{32'h8000_0000}}, 1'b0, '0);
      waitDrain();
      checkOutput("sat_min_linear", data_lin, 32'h8000_0000);

      // Frame marking with a bias load coinciding with pixel 3's acceptance.
      pulseReset();
      last_seen = 0;
      for (int i = 0; i < 33; i++) begin
         px = '0;
         px[DW-1:0] = DW'(i);
         applyStimulus(px, i == 3, 32'd5);
      end
      waitDrain();
      checkOutput("frame_last_count", last_seen, 2);

      // Backpressure window over a 20-pixel stream.
      fork
         begin
            for (int i = 0; i < 20; i++) applyStimulus(randPixel(), 1'b0, '0);
         end
         begin
            repeat (10) @(posedge Clk);
            #1 ready_out = 1'b0;
            repeat (5) @(posedge Clk);
            #1 ready_out = 1'b1;
         end
      join
      waitDrain();

      // Reset with five pixels in flight.
      for (int i = 0; i < 5; i++) applyStimulus(randPixel(), 1'b0, '0);
      pulseReset();
      for (int i = 0; i < 8; i++) begin
         checkOutput("flush_no_valid", valid_out, 1'b0);
         @(posedge Clk);
         #1;
      end
      last_seen = 0;
      for (int i = 0; i < 16; i++) applyStimulus(randPixel(), 1'b0, '0);
      waitDrain();
      checkOutput("post_reset_last_count", last_seen, 1);

      // Random stream with random backpressure and bias reloads.
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++)
               applyStimulus(randPixel(), $urandom_range(0, 7) == 0, $urandom());
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge Clk);
               #1;
               ready_out = ($urandom_range(0, 3) != 0);
            end
            ready_out = 1'b1;
         end
      join
      waitDrain();

      $display("%0d/%0d checks passed", num_passed, num_checks);
      $finish;
   end

endmodule
